// File: rtl/program_loader.sv
// Streams a little-endian byte program (16-bit word count header, then words) into
// instruction memory, holding the core in reset until every word has been written.
module program_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              load_req,
    output logic              WE_i_mem,
    output logic [31:0]       WD_i_mem,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        StHdrLo,
        StHdrHi,
        StLoad,
        StDone,
        StError
    } state_t;

    state_t            r_state, w_state_d;
    logic [1:0]        r_byte_cnt, w_byte_cnt_d;
    logic [15:0]       r_word_cnt, w_word_cnt_d;
    logic [15:0]       r_n, w_n_d;
    logic [23:0]       r_buf, w_buf_d;
    logic              r_ready, w_ready_d;
    logic              r_we, w_we_d;
    logic [31:0]       r_wd, w_wd_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic              r_core_reset, w_core_reset_d;
    logic              r_done, w_done_d;
    logic              r_error, w_error_d;

    logic              w_accept;
    logic [15:0]       w_n_full;
    logic [17:0]       w_addr_full;

    assign w_accept    = byte_valid & r_ready;
    assign w_n_full    = {byte_data, r_n[7:0]};
    assign w_addr_full = {r_word_cnt, 2'b00};

    always_comb begin
        w_state_d      = r_state;
        w_byte_cnt_d   = r_byte_cnt;
        w_word_cnt_d   = r_word_cnt;
        w_n_d          = r_n;
        w_buf_d        = r_buf;
        w_we_d         = 1'b0;
        w_wd_d         = r_wd;
        w_addr_d       = r_addr;
        w_core_reset_d = r_core_reset;
        w_done_d       = r_done;
        w_error_d      = r_error;

        case (r_state)
            StHdrLo: begin
                if (w_accept) begin
                    w_n_d     = {8'h00, byte_data};
                    w_state_d = StHdrHi;
                end
            end
            StHdrHi: begin
                if (w_accept) begin
                    w_n_d = w_n_full;
                    if (w_n_full == 16'd0) begin
                        w_state_d      = StDone;
                        w_core_reset_d = 1'b0;
                        w_done_d       = 1'b1;
                    end else if (32'(w_n_full) > MAX_WORDS) begin
                        w_state_d = StError;
                        w_error_d = 1'b1;
                    end else begin
                        w_state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                // The final WE cycle is still spent in StLoad; release happens on the edge ending it.
                if (r_word_cnt == r_n) begin
                    w_state_d      = StDone;
                    w_core_reset_d = 1'b0;
                    w_done_d       = 1'b1;
                end else if (w_accept) begin
                    w_byte_cnt_d = r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0: w_buf_d[7:0]   = byte_data;
                        2'd1: w_buf_d[15:8]  = byte_data;
                        2'd2: w_buf_d[23:16] = byte_data;
                        default: begin
                            w_wd_d       = {byte_data, r_buf};
                            w_addr_d     = w_addr_full[ADDR_W-1:0];
                            w_we_d       = 1'b1;
                            w_word_cnt_d = r_word_cnt + 16'd1;
                        end
                    endcase
                end
            end
            StDone, StError: begin
                if (load_req) begin
                    w_state_d      = StHdrLo;
                    w_byte_cnt_d   = 2'd0;
                    w_word_cnt_d   = 16'd0;
                    w_core_reset_d = 1'b1;
                    w_done_d       = 1'b0;
                    w_error_d      = 1'b0;
                end
            end
            default: w_state_d = StHdrLo;
        endcase

        w_ready_d = (w_state_d == StHdrLo) || (w_state_d == StHdrHi) || (w_state_d == StLoad);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= StHdrLo;
            r_byte_cnt   <= 2'd0;
            r_word_cnt   <= 16'd0;
            r_n          <= 16'd0;
            r_buf        <= 24'd0;
            r_ready      <= 1'b0;
            r_we         <= 1'b0;
            r_wd         <= 32'd0;
            r_addr       <= '0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_byte_cnt   <= w_byte_cnt_d;
            r_word_cnt   <= w_word_cnt_d;
            r_n          <= w_n_d;
            r_buf        <= w_buf_d;
            r_ready      <= w_ready_d;
            r_we         <= w_we_d;
            r_wd         <= w_wd_d;
            r_addr       <= w_addr_d;
            r_core_reset <= w_core_reset_d;
            r_done       <= w_done_d;
            r_error      <= w_error_d;
        end
    end

    assign byte_ready = r_ready;
    assign WE_i_mem   = r_we;
    assign WD_i_mem   = r_wd;
    assign imem_addr  = r_addr;
    assign core_reset = r_core_reset;
    assign load_done  = r_done;
    assign load_error = r_error;

endmodule
